serial_and16: RTL and testbench
===============================

Name: serial_and16

Overview:
- Bit-serial counterpart to the parallel 16-bit bitwise gate bank.
- Accepts two operand words on a start strobe and evaluates one bit per clock, LSB first, through a single 1-bit logic cell.
- Presents the completed word on a held output register with a done pulse.
- Used in area-constrained datapaths where one shared gate plus a counter replaces 16 parallel gates.

Parameters:
- WIDTH, 16, operand/result width in bits (>=2).
- CNT_W, 4, counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-high reset
- start  input  1  request; sampled on rising clk
- a  input  WIDTH  operand A, sampled only on accepted start
- b  input  WIDTH  operand B, sampled only on accepted start
- op  input  2  function select, sampled on accepted start: 00 AND, 01 OR, 10 NAND, 11 NOT a (b ignored)
- busy  output  1  high while bits are being evaluated
- done  output  1  single-cycle pulse when out is updated
- out  output  WIDTH  result register, held between operations

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset (async assert, any state, including mid-operation):
  - state=IDLE, busy=0, done=0, out=0, counter=0.
  - Internal shift registers are cleared; any in-flight operation is discarded and no done pulse is produced.
  - Leaving reset: the first rising edge with reset low is a normal edge.
- States: IDLE, BUSY, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge: latch a, b, op into shift registers sa, sb, sop; cnt<=0; goto BUSY.
  - start=0: stay.
- BUSY:
  - busy=1.
  - Each edge: r = f(sop, sa[0], sb[0]). The result shift register sr shifts right with r entering at bit WIDTH-1; sa and sb shift right; cnt<=cnt+1.
  - When cnt==WIDTH-1 at an edge, that bit is the last: goto DONE and load out with the completed word. Bit i of out equals f(a[i], b[i]).
  - start in BUSY is ignored; no queuing; a/b/op changes are ignored.
- DONE:
  - busy=0, done=1 for exactly this one cycle. out is already valid.
  - Next edge: if start=1, accept a new operation exactly as in IDLE (back-to-back); else goto IDLE.
- Latency: start accepted at edge N -> out valid and done=1 after edge N+WIDTH; busy high for WIDTH cycles.
- Throughput: one operation per WIDTH+1 cycles with start held high continuously.
- out changes only on entry to DONE and on reset; it never shows partial results.
- Counter never wraps past WIDTH-1; cnt is don't-care outside BUSY but is reset to 0.
- Equal/degenerate operands (all zeros, all ones, a==b) need no special handling.

Optional Feature:
- Macro SERIAL_AND16_ZERO_FLAG_EN.
- Defined:
  - Adds output port zr (1 bit).
  - A sticky accumulator, cleared on accepted start, ORs each evaluated bit r.
  - zr is loaded with the inverted accumulator on entry to DONE, so zr=1 iff the result is all zeros.
  - zr holds with out until the next completion. Reset value is 0.
- Undefined: no zr port, no accumulator logic; all other behaviour is identical.

Test Plan:
- Reset while idle, then start with a=16'hF0F0, b=16'hFF00, op=00 -> busy high 16 cycles, done pulse at edge N+16, out=16'hF000; with macro, zr=0.
- op=01 (OR), a=16'h1234, b=16'h00FF -> out=16'h12FF; op=10 (NAND), a=16'hFFFF, b=16'hFFFF -> out=16'h0000 (zr=1 with macro); op=11, a=16'hAAAA -> out=16'h5555.
- Toggle start, a, and b randomly during BUSY of a=16'hFFFF AND b=16'h8001 -> out=16'h8001 exactly once, no extra done pulse, no restart.
- Hold start=1 continuously with two queued operand sets -> done pulses 17 cycles apart, each out correct; out stable between pulses.
- Assert reset asynchronously (mid-cycle) at bit 7 of an operation -> busy/done/out drop to 0 immediately; no done pulse follows; a subsequent fresh operation completes correctly.
- Check that out keeps its previous value throughout a following BUSY period until the new done pulse.

Source files
------------

// File: rtl/serial_and16.sv
// serial_and16 - bit-serial 2-input logic unit.
//
// Evaluates one bit per clock, LSB first, through a single shared 1-bit
// logic cell. One accepted start produces a full WIDTH-bit result WIDTH
// clocks later. The result is published on 'out' together with a
// one-cycle 'done' pulse. 'out' holds that value until the next completion.
//
// Functions (op):
//   00 AND
//   01 OR
//   10 NAND
//   11 NOT a (b ignored)
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset
//   start  in   operation request, sampled in IDLE and DONE
//   a, b   in   operands, WIDTH bits, captured on an accepted start
//   op     in   2-bit function select, captured on an accepted start
//   busy   out  high while bits are being evaluated (WIDTH cycles)
//   done   out  one-cycle pulse when 'out' has just been updated
//   out    out  WIDTH-bit result register
//   zr     out  (only with SERIAL_AND16_ZERO_FLAG_EN) 1 iff 'out' is all zeros
//
// Optional feature: define SERIAL_AND16_ZERO_FLAG_EN to add the 'zr' port
// and its sticky accumulator.

module serial_and16 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out
`ifdef SERIAL_AND16_ZERO_FLAG_EN
  ,
  output logic             zr
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Count value seen on the edge that evaluates the final bit.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic [1:0]       sop;
  logic [CNT_W-1:0] cnt;
  logic             r;
  logic [WIDTH-1:0] sr_next;

`ifdef SERIAL_AND16_ZERO_FLAG_EN
  logic             acc;
`endif

  // The single shared logic cell. It only ever sees the current LSBs.
  always_comb begin
    r = 1'b0;
    case (sop)
      2'b00:   r = sa[0] & sb[0];
      2'b01:   r = sa[0] | sb[0];
      2'b10:   r = ~(sa[0] & sb[0]);
      default: r = ~sa[0];
    endcase
  end

  // New bits enter at the MSB. After WIDTH shifts the first bit
  // evaluated (bit 0) has reached position 0.
  assign sr_next = {r, sr[WIDTH-1:1]};

  // Control, operand shifters and the output registers share one block,
  // so that busy/done/out are all registered and change together with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      out   <= '0;
      cnt   <= '0;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      sop   <= 2'b00;
`ifdef SERIAL_AND16_ZERO_FLAG_EN
      acc   <= 1'b0;
      zr    <= 1'b0;
`endif
    end else begin
      case (state)
        // DONE accepts a new request just like IDLE. This gives
        // back-to-back operations every WIDTH+1 cycles.
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            sop   <= op;
            sr    <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= BUSY;
`ifdef SERIAL_AND16_ZERO_FLAG_EN
            acc   <= 1'b0;
`endif
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        BUSY: begin
          sr <= sr_next;
          sa <= sa >> 1;
          sb <= sb >> 1;
`ifdef SERIAL_AND16_ZERO_FLAG_EN
          acc <= acc | r;
`endif
          if (cnt == LAST) begin
            // The last bit is folded in directly, so 'out' never shows
            // a partially shifted word.
            out   <= sr_next;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
`ifdef SERIAL_AND16_ZERO_FLAG_EN
            zr    <= ~(acc | r);
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_and16.sv
// tb_serial_and16 - self-checking bench for serial_and16.
// Directed and random operations are checked against a word-level
// reference model of the four functions. The bench also checks the cycle
// timing of busy/done and that 'out' is held between completions.
// Define SERIAL_AND16_ZERO_FLAG_EN to also check the zr output.

module tb_serial_and16;

  localparam int WIDTH = 16;

  logic             clk;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
`ifdef SERIAL_AND16_ZERO_FLAG_EN
  logic             zr;
`endif

  int total = 0;
  int bad   = 0;

  // Value that 'out' should currently hold, as tracked by the model.
  logic [WIDTH-1:0] expOut;

  serial_and16 #(.WIDTH(WIDTH), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .op    (op),
    .busy  (busy),
    .done  (done),
    .out   (out)
`ifdef SERIAL_AND16_ZERO_FLAG_EN
    ,
    .zr    (zr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-level reference: the whole result at once, straight from the function table.
  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] ma,
                                             input logic [WIDTH-1:0] mb,
                                             input logic [1:0] mop);
    case (mop)
      2'b00:   return ma & mb;
      2'b01:   return ma | mb;
      2'b10:   return ~(ma & mb);
      default: return ~ma;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [WIDTH-1:0] sa,
                               input logic [WIDTH-1:0] sb, input logic [1:0] sop);
    start = s;
    a     = sa;
    b     = sb;
    op    = sop;
  endtask

  task automatic checkZero(input string tag);
`ifdef SERIAL_AND16_ZERO_FLAG_EN
    checkOutput(tag, {31'd0, zr}, {31'd0, (expOut == '0)});
`endif
  endtask

  // Runs a full operation from one clock after an edge: accept, WIDTH busy
  // cycles, the done pulse, then a return to IDLE. With toggle set, start/a/b/op
  // are scrambled during BUSY and must have no effect.
  task automatic runOp(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                       input logic [1:0] top, input bit toggle, input string tag);
    logic [WIDTH-1:0] prev;
    prev = expOut;
    applyStimulus(1'b1, ta, tb, top);
    @(posedge clk); #1;
    for (int i = 0; i < WIDTH; i++) begin
      if (toggle)
        applyStimulus(1'($urandom), WIDTH'($urandom), WIDTH'($urandom), 2'($urandom));
      else
        start = 1'b0;
      checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
      checkOutput({tag, "_nodone"}, {31'd0, done}, 32'd0);
      checkOutput({tag, "_hold"}, {16'd0, out}, {16'd0, prev});
      @(posedge clk); #1;
    end
    expOut = model(ta, tb, top);
    start  = 1'b0;
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, "_busylow"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_out"}, {16'd0, out}, {16'd0, expOut});
    checkZero({tag, "_zr"});
    @(posedge clk); #1;
    checkOutput({tag, "_pulse"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_idle"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_keep"}, {16'd0, out}, {16'd0, expOut});
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic [1:0]       rop;
    logic [WIDTH-1:0] a1, b1, a2, b2;
    int               doneGap;

    expOut = '0;
    reset  = 1'b1;
    applyStimulus(1'b0, '0, '0, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_out", {16'd0, out}, 32'd0);
    checkZero("rst_zr");
    #3 reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] directed operations");
    runOp(16'hF0F0, 16'hFF00, 2'b00, 1'b0, "and");
    checkOutput("and_val", {16'd0, out}, 32'h0000F000);
    runOp(16'h1234, 16'h00FF, 2'b01, 1'b0, "or");
    checkOutput("or_val", {16'd0, out}, 32'h000012FF);
    runOp(16'hFFFF, 16'hFFFF, 2'b10, 1'b0, "nand");
    checkOutput("nand_val", {16'd0, out}, 32'h00000000);
    runOp(16'hAAAA, 16'h1357, 2'b11, 1'b0, "not");
    checkOutput("not_val", {16'd0, out}, 32'h00005555);

    $display("[TB] inputs toggled during BUSY");
    runOp(16'hFFFF, 16'h8001, 2'b00, 1'b1, "toggle");
    checkOutput("toggle_val", {16'd0, out}, 32'h00008001);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("toggle_norestart", {31'd0, busy}, 32'd0);
      checkOutput("toggle_noextra", {31'd0, done}, 32'd0);
    end

    $display("[TB] back-to-back with start held");
    a1 = 16'hC3A5; b1 = 16'h0FF0;
    a2 = 16'h5A5A; b2 = 16'hFFFF;
    applyStimulus(1'b1, a1, b1, 2'b01);
    @(posedge clk); #1;
    applyStimulus(1'b1, a2, b2, 2'b10);
    doneGap = 0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      @(posedge clk); #1;
      checkOutput("b2b_first_hold", {16'd0, out}, {16'd0, expOut});
    end
    @(posedge clk); #1;
    checkOutput("b2b_done1", {31'd0, done}, 32'd1);
    expOut = model(a1, b1, 2'b01);
    checkOutput("b2b_out1", {16'd0, out}, {16'd0, expOut});
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("b2b_restart", {31'd0, busy}, 32'd1);
    while (done !== 1'b1 && doneGap < 40) begin
      checkOutput("b2b_hold", {16'd0, out}, {16'd0, expOut});
      @(posedge clk); #1;
      doneGap++;
    end
    checkOutput("b2b_gap", doneGap, 32'd16);
    expOut = model(a2, b2, 2'b10);
    checkOutput("b2b_out2", {16'd0, out}, {16'd0, expOut});
    checkZero("b2b_zr");
    @(posedge clk); #1;

    $display("[TB] asynchronous reset mid-operation");
    runOp(16'h00FF, 16'h0F0F, 2'b00, 1'b0, "pre");
    applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, 2'b01);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #4 reset = 1'b1;
    #1;
    checkOutput("arst_busy", {31'd0, busy}, 32'd0);
    checkOutput("arst_done", {31'd0, done}, 32'd0);
    checkOutput("arst_out", {16'd0, out}, 32'd0);
    expOut = '0;
    checkZero("arst_zr");
    repeat (2) @(posedge clk);
    #4 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checkOutput("arst_nodone", {31'd0, done}, 32'd0);
      checkOutput("arst_idle", {31'd0, busy}, 32'd0);
    end
    runOp(16'h1234, 16'h00FF, 2'b01, 1'b0, "fresh");

    $display("[TB] random operations");
    for (int n = 0; n < 24; n++) begin
      ra  = WIDTH'($urandom);
      rb  = (n % 6 == 5) ? ra : WIDTH'($urandom);
      rop = 2'($urandom_range(0, 3));
      runOp(ra, rb, rop, n[0], "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
